// File: rtl/pwm_cmd_pkg.sv
// rtl/pwm_cmd_pkg.sv - shared types and constants for the PWM command ramp
package pwm_cmd_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        S_HDR,
        S_DIR,
        S_SPD,
        S_CHK
    } parse_state_e;

    typedef enum logic {
        O_IDLE,
        O_SEND
    } out_state_e;

    typedef struct packed {
        logic [7:0] dir;
        logic [7:0] spd;
    } pwm_cmd_t;

endpackage

// File: rtl/pwm_cmd_ramp_speed_slew.sv
// rtl/pwm_cmd_ramp_speed_slew.sv - steps current speed toward target by at most STEP per tick
module speed_slew #(
    parameter logic [7:0] STEP = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] tgt,
    output logic [7:0] cur
);

    logic [7:0] r_cur;
    logic [7:0] w_up;
    logic [7:0] w_dn;

    // distances are only meaningful in the direction actually being moved
    assign w_up = tgt - r_cur;
    assign w_dn = r_cur - tgt;
    assign cur  = r_cur;

    // clamp the final step onto the target so the value never overshoots or wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= 8'h00;
        end else if (tick) begin
            if (tgt > r_cur) begin
                r_cur <= (w_up > STEP) ? r_cur + STEP : tgt;
            end else if (tgt < r_cur) begin
                r_cur <= (w_dn > STEP) ? r_cur - STEP : tgt;
            end
        end
    end

endmodule

// File: rtl/pwm_cmd_ramp.sv
// rtl/pwm_cmd_ramp.sv - command frame parser, speed slew and PWM handshake; optional watchdog via PWM_CMD_WATCHDOG_EN
module pwm_cmd_ramp
    import pwm_cmd_pkg::*;
#(
    parameter int         TICK_DIV = 200,
    parameter logic [7:0] STEP     = 8'd4,
    parameter logic [7:0] DIR_CTR  = 8'h80
`ifdef PWM_CMD_WATCHDOG_EN
    ,
    parameter int         TIMEOUT  = 100000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] pwm_data,
    output logic        pwm_valid,
    input  logic        pwm_rdy,
    output logic        frame_ok,
    output logic [7:0]  err_cnt,
    output logic        wd_trip
);

    parse_state_e r_pstate, w_pstate_nxt;
    out_state_e   r_ostate, w_ostate_nxt;
    logic [7:0]   r_dir_byte, r_spd_byte;
    logic [7:0]   r_tgt_dir, r_tgt_spd;
    logic [7:0]   w_cur_spd;
    logic         r_frame_ok;
    logic [7:0]   r_err_cnt;
    logic [31:0]  r_tick_cnt;
    logic         w_tick;
    logic         w_good, w_bad;
    logic         w_wd_expire;
    logic         r_wd_trip;
    pwm_cmd_t     w_cur, r_pwm_data, r_last_sent;
    logic         w_load, w_done;

    // direction has no ramp, so the current direction is the target register itself
    assign w_cur     = '{dir: r_tgt_dir, spd: w_cur_spd};
    assign w_tick    = (r_tick_cnt == 32'(TICK_DIV - 1));
    assign pwm_data  = r_pwm_data;
    assign pwm_valid = (r_ostate == O_SEND);
    assign frame_ok  = r_frame_ok;
    assign err_cnt   = r_err_cnt;

    // free-running slew tick divider
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_tick_cnt <= 32'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
        end
    end

    // parser next state; a frame is judged on its checksum byte
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        if (rx_valid) begin
            case (r_pstate)
                S_HDR: if (rx_data == FRAME_HDR) w_pstate_nxt = S_DIR;
                S_DIR: w_pstate_nxt = S_SPD;
                S_SPD: w_pstate_nxt = S_CHK;
                S_CHK: begin
                    w_pstate_nxt = S_HDR;
                    if (rx_data == (r_dir_byte ^ r_spd_byte)) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                default: w_pstate_nxt = S_HDR;
            endcase
        end
    end

    // parser state, payload capture, frame pulse and saturating error count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pstate   <= S_HDR;
            r_dir_byte <= 8'h00;
            r_spd_byte <= 8'h00;
            r_frame_ok <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            r_pstate   <= w_pstate_nxt;
            r_frame_ok <= w_good;
            if (rx_valid && r_pstate == S_DIR) r_dir_byte <= rx_data;
            if (rx_valid && r_pstate == S_SPD) r_spd_byte <= rx_data;
            if (w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef PWM_CMD_WATCHDOG_EN
    logic [31:0] r_wd_cnt;

    // a good frame in the expiry cycle wins over the trip
    assign w_wd_expire = (r_wd_cnt == 32'(TIMEOUT - 1)) && !w_good;
    assign wd_trip     = r_wd_trip;

    // watchdog counter, reloaded by every good frame and by its own expiry
    always_ff @(posedge clk) begin
        if (rst || w_good || w_wd_expire) begin
            r_wd_cnt <= 32'd0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign wd_trip     = 1'b0;
`endif

    // targets load from good frames, or fall back to neutral/stop on watchdog expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt_dir <= DIR_CTR;
            r_tgt_spd <= 8'h00;
            r_wd_trip <= 1'b0;
        end else if (w_good) begin
            r_tgt_dir <= r_dir_byte;
            r_tgt_spd <= r_spd_byte;
            r_wd_trip <= 1'b0;
        end else if (w_wd_expire) begin
            r_tgt_dir <= DIR_CTR;
            r_tgt_spd <= 8'h00;
            r_wd_trip <= 1'b1;
        end
    end

    speed_slew #(
        .STEP (STEP)
    ) u_speed_slew (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .tgt  (r_tgt_spd),
        .cur  (w_cur_spd)
    );

    // output FSM next state; only the newest value is offered once a handshake completes
    always_comb begin
        w_ostate_nxt = r_ostate;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_ostate)
            O_IDLE: begin
                if (w_cur != r_last_sent) begin
                    w_load       = 1'b1;
                    w_ostate_nxt = O_SEND;
                end
            end
            O_SEND: begin
                if (pwm_rdy) begin
                    w_done       = 1'b1;
                    w_ostate_nxt = O_IDLE;
                end
            end
            default: w_ostate_nxt = O_IDLE;
        endcase
    end

    // output FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ostate <= O_IDLE;
        end else begin
            r_ostate <= w_ostate_nxt;
        end
    end

    // pwm_data is held stable while offered; last_sent records what the PWM stage accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_data  <= '{dir: DIR_CTR, spd: 8'h00};
            r_last_sent <= '{dir: DIR_CTR, spd: 8'h00};
        end else begin
            if (w_load) r_pwm_data <= w_cur;
            if (w_done) r_last_sent <= r_pwm_data;
        end
    end

endmodule

// File: tb/tb_pwm_cmd_ramp.sv
// tb/tb_pwm_cmd_ramp.sv - directed scoreboard bench for pwm_cmd_ramp
module tb_pwm_cmd_ramp;

    localparam int TICK_DIV = 20;
    localparam int TIMEOUT  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] pwm_data;
    logic        pwm_valid;
    logic        pwm_rdy;
    logic        frame_ok;
    logic [7:0]  err_cnt;
    logic        wd_trip;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    pwm_cmd_ramp #(
        .TICK_DIV (TICK_DIV),
        .STEP     (8'd4),
        .DIR_CTR  (8'h80)
`ifdef PWM_CMD_WATCHDOG_EN
        ,
        .TIMEOUT  (TIMEOUT)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pwm_data  (pwm_data),
        .pwm_valid (pwm_valid),
        .pwm_rdy   (pwm_rdy),
        .frame_ok  (frame_ok),
        .err_cnt   (err_cnt),
        .wd_trip   (wd_trip)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] d, input logic [7:0] s, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(d);
        send_byte(s);
        send_byte(c);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] s);
        send_raw(d, s, d ^ s);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !pwm_valid) break;
            cyc();
        end
        check(tag, 16'(sb.size()), 16'd0);
    endtask

    // every accepted transfer must match the oldest expected value
    always @(negedge clk) begin
        if (!rst && pwm_valid && pwm_rdy) begin
            if (sb.size() == 0) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_txn: observed %h required none", pwm_data);
                end
            end else begin
                check("txn", pwm_data, sb.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        pwm_rdy  = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        check("rst_valid", 16'(pwm_valid), 16'd0);
        check("rst_data", pwm_data, 16'h8000);
        check("rst_frame_ok", 16'(frame_ok), 16'd0);
        check("rst_err", 16'(err_cnt), 16'd0);
        check("rst_wd", 16'(wd_trip), 16'd0);

        // 1: direction-only change, minimum latency
        sb.push_back(16'h9000);
        send_frame(8'h90, 8'h00);
        check("t1_frame_ok", 16'(frame_ok), 16'd1);
        check("t1_valid_t1", 16'(pwm_valid), 16'd0);
        cyc();
        check("t1_valid_t2", 16'(pwm_valid), 16'd1);
        check("t1_data_t2", pwm_data, 16'h9000);
        wait_drain("t1_drain", 50);

        // 2: ramp 0 -> 0x10 in four steps
        sb.push_back(16'h8000);
        sb.push_back(16'h8004);
        sb.push_back(16'h8008);
        sb.push_back(16'h800C);
        sb.push_back(16'h8010);
        send_frame(8'h80, 8'h10);
        wait_drain("t2_drain", 300);
        repeat (60) cyc();
        check("t2_idle_valid", 16'(pwm_valid), 16'd0);
        check("t2_idle_data", pwm_data, 16'h8010);

        // 3: bad checksums, saturating error count
        send_raw(8'h80, 8'h10, 8'h11);
        check("t3_no_frame_ok", 16'(frame_ok), 16'd0);
        check("t3_err1", 16'(err_cnt), 16'd1);
        repeat (5) cyc();
        check("t3_no_valid", 16'(pwm_valid), 16'd0);
        for (int i = 2; i <= 260; i++) begin
            send_raw(8'h00, 8'h00, 8'h01);
            if (i == 254) check("t3_err254", 16'(err_cnt), 16'h00FE);
            if (i == 255) check("t3_err255", 16'(err_cnt), 16'h00FF);
            if (i % 50 == 0) send_frame(8'h80, 8'h10);
        end
        check("t3_err_sat", 16'(err_cnt), 16'h00FF);
        check("t3_no_valid_end", 16'(pwm_valid), 16'd0);

        // 4: backpressure while ramping; newest value follows the stalled one
        pwm_rdy = 1'b0;
        sb.push_back(16'h8014);
        sb.push_back(16'h8040);
        send_frame(8'h80, 8'h40);
        for (int k = 0; k < 8; k++) begin
            repeat (100) cyc();
            check("t4_frozen_valid", 16'(pwm_valid), 16'd1);
            check("t4_frozen_data", pwm_data, 16'h8014);
        end
        pwm_rdy = 1'b1;
        wait_drain("t4_drain", 20);

        // 5: ramp down to 0x10, then watchdog behaviour
        for (int v = 8'h3C; v >= 8'h10; v -= 4) sb.push_back({8'h80, 8'(v)});
        send_frame(8'h80, 8'h10);
`ifdef PWM_CMD_WATCHDOG_EN
        sb.push_back(16'h800C);
        sb.push_back(16'h8008);
        sb.push_back(16'h8004);
        sb.push_back(16'h8000);
        repeat (TIMEOUT - 1) cyc();
        check("t5_wd_before", 16'(wd_trip), 16'd0);
        cyc();
        check("t5_wd_trip", 16'(wd_trip), 16'd1);
        wait_drain("t5_drain", 200);
        check("t5_wd_sticky", 16'(wd_trip), 16'd1);
        send_frame(8'h80, 8'h00);
        check("t5_wd_clear", 16'(wd_trip), 16'd0);
        check("t5_frame_ok", 16'(frame_ok), 16'd1);
`else
        repeat (TIMEOUT + 100) cyc();
        check("t5_no_wd", 16'(wd_trip), 16'd0);
        wait_drain("t5_drain", 50);
        check("t5_hold", pwm_data, 16'h8010);
`endif

        // 6: reset mid-frame discards the partial frame
        send_byte(8'hA5);
        send_byte(8'h90);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_data", pwm_data, 16'h8000);
        check("t6_rst_valid", 16'(pwm_valid), 16'd0);
        check("t6_rst_err", 16'(err_cnt), 16'd0);
        sb.push_back(16'h2000);
        send_frame(8'h20, 8'h00);
        check("t6_frame_ok", 16'(frame_ok), 16'd1);
        cyc();
        check("t6_valid", 16'(pwm_valid), 16'd1);
        check("t6_data", pwm_data, 16'h2000);
        wait_drain("t6_drain", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
